fsm_job_arbiter: RTL and testbench

- Shares one start/wait/finish job engine between N requesters. The engine is a three-state FSM: IDLE=2'b00, BUSY=2'b01, WAITING=2'b10.
- Picks one requester using round-robin, issues a single start pulse, and tracks the job to completion.
- Forwards the owner's pause request to the engine's wait input.
- Reports completion or timeout abort back to the owning requester.
- Sits between the requester ports and the engine. It is the only driver of the engine's i_start and i_wait.

---
 rtl/fsm_pkg.sv | 20 ++
 rtl/rr_pick.sv | 29 ++
 rtl/fsm_job_arbiter.sv | 121 ++++++++++++
 tb/tb_fsm_job_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared type definitions for the job engine and the job arbiter.
// The engine state encoding is fixed because the engine reports it directly.
package fsm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUSY    = 2'b01,
      WAITING = 2'b10
   } eng_state_t;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_START = 3'd1,
      ARB_BUSY  = 3'd2,
      ARB_PAUSE = 3'd3,
      ARB_DONE  = 3'd4,
      ARB_ABORT = 3'd5
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above the
// pointer, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int OWNER_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [OWNER_W-1:0] i_ptr,
   output logic [OWNER_W-1:0] o_winner,
   output logic               o_valid
);

   logic [OWNER_W-1:0] w_idx;

   // Walk offsets from farthest to nearest so the nearest hit overwrites.
   always_comb begin
      o_winner = '0;
      w_idx    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = OWNER_W'((int'(i_ptr) + k) % NUM_REQ);
         if (i_req[w_idx]) begin
            o_winner = w_idx;
         end
      end
   end

   assign o_valid = |i_req;

endmodule

// File: rtl/fsm_job_arbiter.sv
// Round-robin arbiter sharing one start/wait/finish job engine between
// NUM_REQ requesters, with pause forwarding and a BUSY-time watchdog.
module fsm_job_arbiter
   import fsm_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int OWNER_W        = $clog2(NUM_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_pause,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [OWNER_W-1:0] o_owner,
   output logic [NUM_REQ-1:0] o_done,
   output logic [NUM_REQ-1:0] o_abort,
   output logic               o_eng_start,
   output logic               o_eng_wait,
   input  logic               i_eng_finish,
   input  logic [1:0]         i_eng_state,
   output logic [2:0]         o_dbg_state
);

   localparam int                TMR_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

   arb_state_t         r_state, w_state_nxt;
   logic [OWNER_W-1:0] r_owner, w_owner_nxt;
   logic [OWNER_W-1:0] r_ptr,   w_ptr_nxt;
   logic [TMR_W-1:0]   r_timer, w_timer_nxt;

   logic [OWNER_W-1:0] w_pick;
   logic               w_pick_valid;
   logic               w_own_pause;
   logic               w_job;
   logic [NUM_REQ-1:0] w_onehot;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_winner (w_pick),
      .o_valid  (w_pick_valid)
   );

   assign w_own_pause = i_pause[r_owner];

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_timer_nxt = r_timer;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_valid && (i_eng_state == IDLE)) begin
               w_state_nxt = ARB_START;
               w_owner_nxt = w_pick;
            end
         end
         ARB_START: begin
            w_timer_nxt = '0;
            w_state_nxt = ARB_BUSY;
         end
         ARB_BUSY: begin
            // Saturate at the limit so the timer can never wrap.
            if (r_timer != TMR_MAX) begin
               w_timer_nxt = r_timer + 1'b1;
            end
            if (i_eng_finish) begin
               w_state_nxt = ARB_DONE;
            end else if (r_timer == TMR_MAX) begin
               w_state_nxt = ARB_ABORT;
            end else if (w_own_pause) begin
               w_state_nxt = ARB_PAUSE;
            end
         end
         ARB_PAUSE: begin
            if (i_eng_finish) begin
               w_state_nxt = ARB_DONE;
            end else if (!w_own_pause) begin
               w_state_nxt = ARB_BUSY;
            end
         end
         ARB_DONE, ARB_ABORT: begin
            w_ptr_nxt   = (r_owner == OWNER_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
            w_state_nxt = ARB_IDLE;
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ARB_IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // All outputs decode registered state only, so reset clears them at once.
   assign w_job       = (r_state != ARB_IDLE);
   assign w_onehot    = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
   assign o_gnt       = w_job ? w_onehot : '0;
   assign o_owner     = w_job ? r_owner : '0;
   assign o_eng_start = (r_state == ARB_START);
   assign o_eng_wait  = (r_state == ARB_PAUSE);
   assign o_done      = (r_state == ARB_DONE)  ? w_onehot : '0;
   assign o_abort     = (r_state == ARB_ABORT) ? w_onehot : '0;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Self-checking bench for fsm_job_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a job-level reference model.
module tb_fsm_job_arbiter;

   localparam int N = 4;
   localparam int T = 16;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic [N-1:0] i_req;
   logic [N-1:0] i_pause;
   logic [N-1:0] o_gnt;
   logic [1:0]   o_owner;
   logic [N-1:0] o_done;
   logic [N-1:0] o_abort;
   logic         o_eng_start;
   logic         o_eng_wait;
   logic         i_eng_finish;
   logic [1:0]   i_eng_state;
   logic [2:0]   o_dbg_state;

   fsm_job_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_req        (i_req),
      .i_pause      (i_pause),
      .o_gnt        (o_gnt),
      .o_owner      (o_owner),
      .o_done       (o_done),
      .o_abort      (o_abort),
      .o_eng_start  (o_eng_start),
      .o_eng_wait   (o_eng_wait),
      .i_eng_finish (i_eng_finish),
      .i_eng_state  (i_eng_state),
      .o_dbg_state  (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 i_clk = ~i_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model (job level) ----------------
   bit         m_active, m_start, m_paused, m_done, m_abort;
   int         m_owner, m_ptr, m_busy;
   logic [1:0] exp_q[$];
   int         grant_q[$];
   int         n_wait, n_done, n_abort;

   task automatic model_reset();
      m_active = 0; m_start = 0; m_paused = 0; m_done = 0; m_abort = 0;
      m_owner  = 0; m_ptr = 0; m_busy = 0;
      exp_q.delete();
   endtask

   function automatic int pick(input logic [N-1:0] req);
      for (int k = 0; k < N; k++) begin
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return 0;
   endfunction

   // Advance the model by one clock using the inputs sampled at that edge.
   task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] pause,
                             input logic fin, input logic [1:0] est);
      if (m_done || m_abort) begin
         m_ptr    = (m_owner + 1) % N;
         m_active = 0; m_done = 0; m_abort = 0;
      end else if (!m_active) begin
         if (req != 0 && est == 2'b00) begin
            m_owner  = pick(req);
            m_active = 1; m_start = 1; m_busy = 0;
            exp_q.push_back(2'(m_owner));
         end
      end else if (m_start) begin
         m_start = 0;
      end else if (m_paused) begin
         if (fin) begin
            m_paused = 0; m_done = 1;
         end else if (!pause[m_owner]) begin
            m_paused = 0;
         end
      end else begin
         m_busy++;
         if (fin)                 m_done   = 1;
         else if (m_busy == T)    m_abort  = 1;
         else if (pause[m_owner]) m_paused = 1;
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] one;
      one = 4'b0001 << m_owner;
      check_eq("gnt",   o_gnt,       m_active ? one : '0);
      if (m_active) check_eq("owner", o_owner, m_owner);
      check_eq("start", o_eng_start, m_start);
      check_eq("wait",  o_eng_wait,  m_paused);
      check_eq("done",  o_done,      m_done  ? one : '0);
      check_eq("abort", o_abort,     m_abort ? one : '0);
      if (o_eng_start) begin
         grant_q.push_back(o_owner);
         if (exp_q.size() == 0) check_eq("sb_pending", exp_q.size(), 1);
         else                   check_eq("sb_owner", o_owner, exp_q.pop_front());
      end
      if (o_eng_wait)  n_wait++;
      if (|o_done)     n_done++;
      if (|o_abort)    n_abort++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] pause,
                      input logic fin, input logic [1:0] est);
      i_req = req; i_pause = pause; i_eng_finish = fin; i_eng_state = est;
      model_step(req, pause, fin, est);
      @(posedge i_clk);
      @(negedge i_clk);
      check_outputs();
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_req = '0; i_pause = '0; i_eng_finish = 1'b0; i_eng_state = 2'b00;
      @(posedge i_clk);
      @(negedge i_clk);
      model_reset();
      check_outputs();
      check_eq("rst_owner", o_owner, 0);
      i_rst = 1'b0;
      grant_q.delete();
      n_wait = 0; n_done = 0; n_abort = 0;
   endtask

   task automatic wait_start(input logic [N-1:0] req, input int bound);
      bit seen;
      seen = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         cyc(req, '0, 1'b0, 2'b00);
         seen = o_eng_start;
      end
      check_eq("start_seen", seen, 1);
   endtask

   task automatic finish_job(input logic [N-1:0] req);
      bit seen;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cyc(req, '0, 1'b1, 2'b00);
         seen = (o_done != 0);
      end
      check_eq("job_done_seen", seen, 1);
      cyc('0, '0, 1'b0, 2'b00);
   endtask

   // ---------------- stimulus ----------------
   int           exp_order[5] = '{0, 1, 2, 3, 0};
   int           at;
   logic [N-1:0] rq;

   initial begin
      @(negedge i_clk);

      // 1: single request, latency and pointer advance
      do_reset();
      cyc(4'b0100, '0, 1'b0, 2'b00);
      check_eq("t1_gnt", o_gnt, 4'b0100);
      check_eq("t1_start", o_eng_start, 1);
      repeat (4) cyc(4'b0100, '0, 1'b0, 2'b00);
      cyc(4'b0100, '0, 1'b1, 2'b00);
      check_eq("t1_done", o_done, 4'b0100);
      cyc('0, '0, 1'b0, 2'b00);
      check_eq("t1_done_once", o_done, 0);
      cyc(4'b1001, '0, 1'b0, 2'b00);
      check_eq("t1_ptr_owner", o_owner, 3);
      finish_job(4'b1001);

      // 2: round-robin fairness with all requesting
      do_reset();
      repeat (5) begin
         wait_start(4'b1111, 8);
         repeat (2) cyc(4'b1111, '0, 1'b0, 2'b00);
         cyc(4'b1111, '0, 1'b1, 2'b00);
      end
      check_eq("t2_count", grant_q.size(), 5);
      for (int i = 0; i < 5 && i < grant_q.size(); i++) check_eq("t2_order", grant_q[i], exp_order[i]);
      for (int i = 1; i < grant_q.size(); i++) check_eq("t2_no_repeat", grant_q[i] == grant_q[i-1], 0);

      // 3: pause freezes the timer; finish during pause completes
      do_reset();
      cyc(4'b0010, '0, 1'b0, 2'b00);
      repeat (10) cyc(4'b0010, '0, 1'b0, 2'b00);
      n_wait = 0;
      repeat (6) cyc(4'b0010, 4'b0010, 1'b0, 2'b00);
      repeat (4) cyc(4'b0010, 4'b1101, 1'b0, 2'b00);
      check_eq("t3_wait_cycles", n_wait, 6);
      repeat (2) cyc(4'b0010, 4'b0010, 1'b0, 2'b00);
      check_eq("t3_wait_level", o_eng_wait, 1);
      cyc(4'b0010, 4'b0010, 1'b1, 2'b00);
      check_eq("t3_done", o_done, 4'b0010);
      cyc('0, '0, 1'b0, 2'b00);
      check_eq("t3_no_abort", n_abort, 0);

      // 4: timeout abort and pointer advance
      do_reset();
      cyc(4'b0011, '0, 1'b0, 2'b00);
      at = -1;
      for (int i = 1; i <= 20 && at < 0; i++) begin
         cyc(4'b0011, '0, 1'b0, 2'b00);
         if (o_abort != 0) begin
            at = i;
            check_eq("t4_abort_vec", o_abort, 4'b0001);
         end
      end
      check_eq("t4_abort_cycle", at, 17);
      check_eq("t4_no_done", n_done, 0);
      wait_start(4'b0011, 4);
      check_eq("t4_next_owner", o_owner, 1);
      finish_job(4'b0011);

      // 5: engine not idle blocks the grant
      do_reset();
      repeat (2) begin
         cyc(4'b0001, '0, 1'b0, 2'b01);
         check_eq("t5_no_gnt", o_gnt, 0);
         check_eq("t5_no_start", o_eng_start, 0);
      end
      cyc(4'b0001, '0, 1'b0, 2'b10);
      check_eq("t5_no_gnt_wait", o_gnt, 0);
      cyc(4'b0001, '0, 1'b0, 2'b00);
      check_eq("t5_gnt", o_gnt, 4'b0001);
      check_eq("t5_start", o_eng_start, 1);
      finish_job(4'b0001);

      // 6: asynchronous reset while paused
      do_reset();
      cyc(4'b0010, '0, 1'b0, 2'b00);
      repeat (2) cyc(4'b0010, '0, 1'b0, 2'b00);
      cyc(4'b0010, 4'b0010, 1'b0, 2'b00);
      check_eq("t6_paused", o_eng_wait, 1);
      #2 i_rst = 1'b1;
      #1;
      check_eq("t6_rst_gnt", o_gnt, 0);
      check_eq("t6_rst_wait", o_eng_wait, 0);
      check_eq("t6_rst_owner", o_owner, 0);
      model_reset();
      @(negedge i_clk);
      i_rst = 1'b0;
      cyc(4'b1000, '0, 1'b0, 2'b00);
      check_eq("t6_owner", o_owner, 3);
      check_eq("t6_gnt", o_gnt, 4'b1000);
      finish_job(4'b1000);

      // random traffic against the model
      do_reset();
      rq = '0;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < N; i++) if (!rq[i] && $urandom_range(0, 3) == 0) rq[i] = 1'b1;
         if (m_active && !m_start && $urandom_range(0, 31) == 0) rq[m_owner] = 1'b0;
         cyc(rq, N'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'b00);
         for (int i = 0; i < N; i++) if (o_done[i] || o_abort[i]) rq[i] = 1'($urandom_range(0, 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
